sd_bd_ring: RTL and testbench
=============================

// Module: sd_bd_ring
// PURPOSE
//  Circular buffer-descriptor (BD) store feeding the SD data master; one instance each for TX and RX.
//  Host side writes 2-word BDs: word0 = sys_adr, word1 = cmd_arg.
//  Master side reads BD words over a re/ack handshake and retires the head BD with a_cmp.
//  Exports free_bd; the data master treats free_bd != BD_COUNT as "BD pending".
// PARAMETERS
//  BD_COUNT  8  number of BD slots (power of 2); storage is 2*BD_COUNT x 32 bits
//  BD_AW     3  log2(BD_COUNT)
//  BD_W      4  width of free_bd; must hold BD_COUNT
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous reset, active-high
//  clr        in   1      synchronous clear: empty ring, abort reads
//  wr_en      in   1      host write strobe, one word per cycle
//  wr_dat     in   32     host write data
//  wr_ack     out  1      word accepted (registered, 1-cycle pulse)
//  wr_err     out  1      write rejected, ring full (1-cycle pulse)
//  free_bd    out  BD_W   free BD slots, BD_COUNT = empty
//  re_s       in   1      master read request, level
//  ack_o_s    out  1      read data valid (1-cycle pulse)
//  dat_out_s  out  32     read data, held until next ack
//  a_cmp      in   1      master retires head BD (1-cycle pulse)
// BEHAVIOUR
//  Reset: wr_ack=0, wr_err=0, ack_o_s=0, dat_out_s=0, free_bd=BD_COUNT.
//   All pointers, offsets and hw_half are zero. RAM contents are not reset.
//  Host write pointer wp (BD_AW bits) plus hw_half flag.
//  Write when free_bd!=0: store to RAM[{wp,hw_half}], wr_ack=1 next cycle, toggle hw_half.
//   When hw_half was 1 (second word): wp++ (wraps mod BD_COUNT), free_bd--.
//  Write when free_bd==0: nothing stored, wr_err=1 next cycle, hw_half unchanged.
//  free_bd drops only on the second word; a half-written BD is never visible to the master.
//  Read side: head pointer rp (BD_AW bits), word offset ro (1 bit), plus an ro_done flag.
//  Read FSM:
//   R_IDLE: if re_s && free_bd!=BD_COUNT && !ro_done -> dat_out_s<=RAM[{rp,ro}], ack_o_s<=1, go R_ACK.
//    If re_s is low: ro<=0, ro_done<=0 (reread restarts at word0 of the same head BD).
//   R_ACK: ack_o_s<=0. If ro==1: ro_done<=1, else ro<=1. Go R_GAP.
//   R_GAP: 1-cycle gap so the master can drop re_s; go R_IDLE.
//  Ack cadence: at most one ack per 3 cycles; latency from re_s high (R_IDLE) to ack_o_s = 1 clk.
//  After 2 words (ro_done) no further acks until re_s drops or a_cmp arrives.
//  a_cmp with free_bd!=BD_COUNT: rp++ (wrap), ro<=0, ro_done<=0, free_bd++.
//   Read FSM returns to R_IDLE; a pending ack_o_s is still cleared.
//  a_cmp with free_bd==BD_COUNT: ignored.
//  Same-cycle second-word write and a_cmp: free_bd unchanged, both pointers advance.
//  Write into the head BD's slots is impossible: head slot is not free until retired.
//  clr, priority over everything except rst: wp=rp=0, hw_half=ro=ro_done=0, free_bd=BD_COUNT.
//   clr also forces R_IDLE and ack_o_s=0. wr_en and a_cmp in the clr cycle are dropped (no wr_ack/wr_err).
//  rst mid-transfer: immediate return to reset state; an in-flight ack is lost.
//  free_bd arithmetic is BD_W bits, never below 0 or above BD_COUNT (guarded by the rules above).
// TESTING
//  1. Write 0x1000,0xAA -> wr_ack x2, free_bd 8->7 only after 2nd word.
//     re_s=1 -> acks carry 0x1000 then 0xAA; no 3rd ack.
//  2. After test 1, drop re_s 1 cycle then raise it, no a_cmp -> words 0x1000,0xAA re-delivered (retry).
//  3. Write 8 BDs -> free_bd=0. 17th word -> wr_err pulse, no wr_ack.
//     Then a_cmp -> free_bd=1, next write accepted into the wrapped slot 0.
//  4. free_bd=5: 2nd-word write and a_cmp in same cycle -> free_bd stays 5.
//     Next read returns the new head BD.
//  5. a_cmp with ring empty -> free_bd stays 8. clr during R_ACK -> ack_o_s=0, free_bd=8 next cycle.
//  6. Assert rst while ack_o_s=1 -> all outputs 0, free_bd=8 asynchronously.
//     After release, first write lands at slot 0 word0.

Source files
------------

// File: rtl/sd_bd_ring_if.sv
// Bus bundle between the BD ring and its two users: the host that writes
// descriptors and the SD data master that reads and retires them.
interface sd_bd_ring_if #(
  parameter int BD_W = 4
) ();

  logic            clr;
  logic            wr_en;
  logic [31:0]     wr_dat;
  logic            wr_ack;
  logic            wr_err;
  logic [BD_W-1:0] free_bd;
  logic            re_s;
  logic            ack_o_s;
  logic [31:0]     dat_out_s;
  logic            a_cmp;

  // Host plus data-master view: drives the requests, observes the ring.
  modport master (
    output clr, wr_en, wr_dat, re_s, a_cmp,
    input  wr_ack, wr_err, free_bd, ack_o_s, dat_out_s
  );

  // Ring view: answers writes and reads, reports free slots.
  modport slave (
    input  clr, wr_en, wr_dat, re_s, a_cmp,
    output wr_ack, wr_err, free_bd, ack_o_s, dat_out_s
  );

endinterface

// File: rtl/sd_bd_ring.sv
// Circular buffer-descriptor store for the SD data master.
// Each descriptor is two 32-bit words (system address, command argument).
// The host fills descriptors one word per cycle; a descriptor only becomes
// visible to the master once both words are in. The master reads the head
// descriptor word by word over a re/ack handshake and retires it with a_cmp.
module sd_bd_ring #(
  parameter int BD_COUNT = 8,
  parameter int BD_AW    = 3,
  parameter int BD_W     = 4
) (
  input logic         clk,
  input logic         rst,
  sd_bd_ring_if.slave bus
);

  localparam logic [BD_W-1:0]  FREE_MAX = BD_W'(BD_COUNT);
  localparam logic [BD_AW-1:0] PTR_ONE  = BD_AW'(1);
  localparam logic [BD_W-1:0]  CNT_ONE  = BD_W'(1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACK,
    R_GAP
  } rd_state_t;

  // Descriptor storage, two words per slot, addressed {slot, word}.
  logic [31:0] ram [2*BD_COUNT];

  // Host write side.
  logic [BD_AW-1:0] wp;
  logic             hw_half;
  logic             wr_ack_r;
  logic             wr_err_r;

  // Shared occupancy.
  logic [BD_W-1:0]  free_cnt;

  // Master read side.
  logic [BD_AW-1:0] rp;
  logic             ro;
  logic             ro_done;
  logic             ack_r;
  logic [31:0]      dat_r;
  rd_state_t        state;

  // Next-state values from the read FSM.
  rd_state_t        state_next;
  logic             ro_next;
  logic             ro_done_next;
  logic             ack_next;
  logic             load_dat;

  // Decoded events for this cycle.
  logic             ring_empty;
  logic             ring_full;
  logic             wr_accept;
  logic             wr_reject;
  logic             wr_last;
  logic             retire;

  // A clear swallows any write or retire presented in the same cycle, so
  // every event is qualified with !clr here and the registers stay simple.
  assign ring_empty = (free_cnt == FREE_MAX);
  assign ring_full  = (free_cnt == '0);
  assign wr_accept  = bus.wr_en && !ring_full && !bus.clr;
  assign wr_reject  = bus.wr_en &&  ring_full && !bus.clr;
  assign wr_last    = wr_accept && hw_half;
  assign retire     = bus.a_cmp && !ring_empty && !bus.clr;

  assign bus.wr_ack    = wr_ack_r;
  assign bus.wr_err    = wr_err_r;
  assign bus.free_bd   = free_cnt;
  assign bus.ack_o_s   = ack_r;
  assign bus.dat_out_s = dat_r;

  // Descriptor RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      ram[{wp, hw_half}] <= bus.wr_dat;
    end
  end

  // Host write pointer, half-word flag and the one-cycle accept/reject pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      hw_half  <= 1'b0;
      wr_ack_r <= 1'b0;
      wr_err_r <= 1'b0;
    end else if (bus.clr) begin
      wp       <= '0;
      hw_half  <= 1'b0;
      wr_ack_r <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      wr_ack_r <= wr_accept;
      wr_err_r <= wr_reject;
      if (wr_accept) begin
        hw_half <= ~hw_half;
      end
      if (wr_last) begin
        wp <= wp + PTR_ONE;
      end
    end
  end

  // Free-slot counter: a completed descriptor and a retire in the same cycle
  // cancel out; the full/empty guards keep it inside 0..BD_COUNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_cnt <= FREE_MAX;
    end else if (bus.clr) begin
      free_cnt <= FREE_MAX;
    end else if (wr_last && !retire) begin
      free_cnt <= free_cnt - CNT_ONE;
    end else if (retire && !wr_last) begin
      free_cnt <= free_cnt + CNT_ONE;
    end
  end

  // Head pointer advances only when the master retires a pending descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
    end else if (bus.clr) begin
      rp <= '0;
    end else if (retire) begin
      rp <= rp + PTR_ONE;
    end
  end

  // Read FSM next-state logic: clear and retire restart the handshake on
  // word0; otherwise idle -> ack -> gap paces acks at one per three cycles.
  always_comb begin
    state_next   = state;
    ro_next      = ro;
    ro_done_next = ro_done;
    ack_next     = 1'b0;
    load_dat     = 1'b0;
    if (bus.clr || retire) begin
      state_next   = R_IDLE;
      ro_next      = 1'b0;
      ro_done_next = 1'b0;
    end else begin
      case (state)
        R_IDLE: begin
          if (!bus.re_s) begin
            ro_next      = 1'b0;
            ro_done_next = 1'b0;
          end else if (!ring_empty && !ro_done) begin
            load_dat   = 1'b1;
            ack_next   = 1'b1;
            state_next = R_ACK;
          end
        end
        R_ACK: begin
          if (ro) begin
            ro_done_next = 1'b1;
          end else begin
            ro_next = 1'b1;
          end
          state_next = R_GAP;
        end
        R_GAP: begin
          state_next = R_IDLE;
        end
        default: begin
          state_next = R_IDLE;
        end
      endcase
    end
  end

  // Read FSM state, word offset and ack pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= R_IDLE;
      ro      <= 1'b0;
      ro_done <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state   <= state_next;
      ro      <= ro_next;
      ro_done <= ro_done_next;
      ack_r   <= ack_next;
    end
  end

  // Read data register holds the last delivered word until the next ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_r <= '0;
    end else if (load_dat) begin
      dat_r <= ram[{rp, ro}];
    end
  end

endmodule

// File: tb/tb_sd_bd_ring.sv
// Self-checking bench for sd_bd_ring: a queue-based model of the ring is
// compared against the DUT every cycle, and directed tests pin key values.
module tb_sd_bd_ring;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  sd_bd_ring_if #(.BD_W(4)) bus ();

  sd_bd_ring #(
    .BD_COUNT(8),
    .BD_AW   (3),
    .BD_W    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz style clock.
  always #5 clk = ~clk;

  // Model state: pending descriptors as {word0, word1}, plus handshake pacing.
  logic [63:0] q [$];
  logic [31:0] m_first = '0;
  logic [31:0] m_dat = '0;
  bit          m_half = 1'b0;
  bit          m_ack = 1'b0;
  bit          m_wr_ack = 1'b0;
  bit          m_wr_err = 1'b0;
  int          m_sent = 0;
  int          m_busy = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the ring, advanced on each clock edge.
  always @(posedge clk or posedge rst) begin : model
    int sz;
    bit retire;
    if (rst) begin
      q.delete();
      m_half = 0; m_sent = 0; m_busy = 0;
      m_ack = 0; m_dat = '0; m_wr_ack = 0; m_wr_err = 0;
    end else if (bus.clr) begin
      q.delete();
      m_half = 0; m_sent = 0; m_busy = 0;
      m_ack = 0; m_wr_ack = 0; m_wr_err = 0;
    end else begin
      sz       = q.size();
      retire   = bus.a_cmp && (sz > 0);
      m_wr_ack = bus.wr_en && (sz < N);
      m_wr_err = bus.wr_en && (sz == N);
      m_ack    = 0;
      if (retire) begin
        m_sent = 0;
        m_busy = 0;
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (!bus.re_s) begin
        m_sent = 0;
      end else if (sz > 0 && m_sent < 2) begin
        m_dat  = (m_sent == 0) ? q[0][63:32] : q[0][31:0];
        m_sent++;
        m_busy = 2;
        m_ack  = 1;
      end
      if (retire) void'(q.pop_front());
      if (m_wr_ack) begin
        if (m_half) begin
          q.push_back({m_first, bus.wr_dat});
          m_half = 0;
        end else begin
          m_first = bus.wr_dat;
          m_half  = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cyc wr_ack", {31'b0, bus.wr_ack}, {31'b0, m_wr_ack});
      check_output("cyc wr_err", {31'b0, bus.wr_err}, {31'b0, m_wr_err});
      check_output("cyc free_bd", {28'b0, bus.free_bd}, N - q.size());
      check_output("cyc ack_o_s", {31'b0, bus.ack_o_s}, {31'b0, m_ack});
      check_output("cyc dat_out_s", bus.dat_out_s, m_dat);
    end
  end

  // One clock with the given pulses; pulses drop afterwards, re_s is left alone.
  task automatic apply_stimulus(input bit c, input bit w, input logic [31:0] d, input bit a);
    bus.clr    = c;
    bus.wr_en  = w;
    bus.wr_dat = d;
    bus.a_cmp  = a;
    @(posedge clk);
    #1;
    bus.clr   = 1'b0;
    bus.wr_en = 1'b0;
    bus.a_cmp = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input int bound, output bit found, output int cycles, output logic [31:0] data);
    found  = 0;
    cycles = 0;
    data   = '0;
    for (int i = 0; i < bound && !found; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.ack_o_s === 1'b1) begin
        found = 1;
        data  = bus.dat_out_s;
      end
    end
  endtask

  task automatic expect_ack(input string name, input logic [31:0] exp_dat, input int exp_cycles);
    bit          found;
    int          cycles;
    logic [31:0] data;
    wait_ack(8, found, cycles, data);
    check_output({name, " ack seen"}, {31'b0, found}, 32'd1);
    if (found) begin
      check_output({name, " data"}, data, exp_dat);
      check_output({name, " latency"}, cycles, exp_cycles);
      check_output({name, " model data"}, m_dat, exp_dat);
    end
  endtask

  task automatic expect_no_ack(input string name, input int bound);
    bit          found;
    int          cycles;
    logic [31:0] data;
    wait_ack(bound, found, cycles, data);
    check_output({name, " no ack"}, {31'b0, found}, 32'd0);
  endtask

  task automatic check_free(input string name, input int exp);
    check_output({name, " free_bd"}, {28'b0, bus.free_bd}, exp);
    check_output({name, " model free"}, N - q.size(), exp);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.clr = 0; bus.wr_en = 0; bus.wr_dat = '0; bus.re_s = 0; bus.a_cmp = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    $display("[TB] reset state");
    check_free("reset", 8);
    check_output("reset wr_ack", {31'b0, bus.wr_ack}, 32'd0);
    check_output("reset wr_err", {31'b0, bus.wr_err}, 32'd0);
    check_output("reset ack_o_s", {31'b0, bus.ack_o_s}, 32'd0);
    check_output("reset dat_out_s", bus.dat_out_s, 32'd0);

    $display("[TB] test 1: single BD write and read");
    apply_stimulus(0, 1, 32'h1000, 0);
    check_output("t1 wr_ack0", {31'b0, bus.wr_ack}, 32'd1);
    check_free("t1 after word0", 8);
    apply_stimulus(0, 1, 32'hAA, 0);
    check_output("t1 wr_ack1", {31'b0, bus.wr_ack}, 32'd1);
    check_free("t1 after word1", 7);
    bus.re_s = 1'b1;
    expect_ack("t1 w0", 32'h1000, 1);
    expect_ack("t1 w1", 32'hAA, 3);
    expect_no_ack("t1 third", 6);

    $display("[TB] test 2: retry after re_s drop");
    bus.re_s = 1'b0;
    tick(1);
    bus.re_s = 1'b1;
    expect_ack("t2 w0", 32'h1000, 1);
    expect_ack("t2 w1", 32'hAA, 3);
    bus.re_s = 1'b0;
    tick(3);
    apply_stimulus(1, 0, 32'h0, 0);
    check_free("t2 clr", 8);

    $display("[TB] test 3: fill, overflow, wrap");
    for (int i = 0; i < N; i++) begin
      apply_stimulus(0, 1, 32'h30000 + 32'(i * 16), 0);
      apply_stimulus(0, 1, 32'hA0 + 32'(i), 0);
    end
    check_free("t3 full", 0);
    apply_stimulus(0, 1, 32'hDEAD, 0);
    check_output("t3 wr_err", {31'b0, bus.wr_err}, 32'd1);
    check_output("t3 no wr_ack", {31'b0, bus.wr_ack}, 32'd0);
    check_free("t3 after reject", 0);
    apply_stimulus(0, 0, 32'h0, 1);
    check_free("t3 after retire", 1);
    apply_stimulus(0, 1, 32'h5000, 0);
    check_output("t3 wrap wr_ack", {31'b0, bus.wr_ack}, 32'd1);
    apply_stimulus(0, 1, 32'h55, 0);
    check_free("t3 refilled", 0);

    $display("[TB] test 4: simultaneous write and retire");
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 32'h0, 1);
    check_free("t4 five free", 5);
    apply_stimulus(0, 1, 32'h6000, 0);
    apply_stimulus(0, 1, 32'h66, 1);
    check_free("t4 same cycle", 5);
    bus.re_s = 1'b1;
    expect_ack("t4 head w0", 32'h30070, 1);
    expect_ack("t4 head w1", 32'hA7, 3);
    bus.re_s = 1'b0;
    apply_stimulus(0, 0, 32'h0, 1);
    bus.re_s = 1'b1;
    expect_ack("t4 wrapped w0", 32'h5000, 1);
    expect_ack("t4 wrapped w1", 32'h55, 3);
    bus.re_s = 1'b0;
    apply_stimulus(0, 0, 32'h0, 1);
    tick(2);

    $display("[TB] test 5: empty retire and clear during ack");
    apply_stimulus(1, 0, 32'h0, 0);
    check_free("t5 clr", 8);
    apply_stimulus(0, 0, 32'h0, 1);
    check_free("t5 empty retire", 8);
    apply_stimulus(0, 1, 32'h7000, 0);
    apply_stimulus(0, 1, 32'h77, 0);
    bus.re_s = 1'b1;
    expect_ack("t5 w0", 32'h7000, 1);
    apply_stimulus(1, 1, 32'hBAD, 1);
    check_output("t5 clr ack", {31'b0, bus.ack_o_s}, 32'd0);
    check_output("t5 clr wr_ack", {31'b0, bus.wr_ack}, 32'd0);
    check_output("t5 clr wr_err", {31'b0, bus.wr_err}, 32'd0);
    check_free("t5 clr", 8);
    expect_no_ack("t5 after clr", 4);
    bus.re_s = 1'b0;
    tick(1);

    $display("[TB] test 6: asynchronous reset mid-transfer");
    apply_stimulus(0, 1, 32'h8000, 0);
    apply_stimulus(0, 1, 32'h88, 0);
    bus.re_s = 1'b1;
    expect_ack("t6 w0", 32'h8000, 1);
    rst = 1'b1;
    #1;
    check_output("t6 rst ack", {31'b0, bus.ack_o_s}, 32'd0);
    check_output("t6 rst dat", bus.dat_out_s, 32'd0);
    check_output("t6 rst wr_ack", {31'b0, bus.wr_ack}, 32'd0);
    check_free("t6 rst", 8);
    bus.re_s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(0, 1, 32'h9000, 0);
    apply_stimulus(0, 1, 32'h99, 0);
    check_free("t6 after write", 7);
    bus.re_s = 1'b1;
    expect_ack("t6 slot0 w0", 32'h9000, 1);
    expect_ack("t6 slot0 w1", 32'h99, 3);
    bus.re_s = 1'b0;
    tick(3);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
